// File: rtl/uart_pkg.sv
// uart_pkg -- constants and types shared by the UART transmitter and receiver.
//   DATA_W      : data bits per frame (8)
//   STOP_BITS   : stop bits per frame (1)
//   uart_state_t: frame FSM state encodings. ST_PARITY is only entered when the
//                 design is built with UART_TX_PARITY_EN defined.
//   even_parity : XOR of all data bits, so the data bits plus the parity bit
//                 together hold an even number of ones.
package uart_pkg;

  localparam int DATA_W    = 8;
  localparam int STOP_BITS = 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick -- bit-period timer shared by the UART transmitter and receiver.
// Parameter CLK_PER_BIT: clk_i cycles per serial bit (>= 2).
// Ports:
//   clk_i   in  clock, rising edge
//   reset_i in  synchronous active-high reset
//   enable  in  counting enabled; while low the counter is held at 0 so that
//               the first bit after enabling lasts a full period
//   tick    out high in the last cycle of each bit period (counter wrap)
module uart_baud_tick #(
  parameter int CLK_PER_BIT = 16
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic enable,
  output logic tick
);

  localparam int CW_RAW = $clog2(CLK_PER_BIT);
  localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
  localparam logic [CW-1:0] LAST = CW'(CLK_PER_BIT - 1);

  logic [CW-1:0] r_cnt;

  // Bit-period counter: 0 .. CLK_PER_BIT-1, wrapping; parked at 0 when disabled.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_cnt <= '0;
    end else if (!enable) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = enable && (r_cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// uart_tx -- UART transmitter, 8N1 by default, 8E1 when built with the macro
// UART_TX_PARITY_EN defined (even parity bit inserted between bit 7 and stop).
// Parameter CLK_PER_BIT: clk_i cycles per serial bit (>= 2).
// Ports:
//   clk_i   in      clock, rising edge
//   reset_i in      synchronous active-high reset; aborts any frame in progress
//   valid_i in      data_i holds a byte to send
//   ready_o out     byte accepted in a cycle where valid_i && ready_o
//   data_i  in [7:0] byte to transmit, LSB first
//   tx_o    out     registered serial line, idle high
//   busy_o  out     frame in progress
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] data_i,
  output logic              tx_o,
  output logic              busy_o
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_W - 1);

  uart_state_t       r_state;
  logic [DATA_W-1:0] r_shift;
  logic [2:0]        r_bit_idx;
  logic              r_tx;
  logic              r_ready;
  logic              r_busy;
`ifdef UART_TX_PARITY_EN
  logic              r_parity;
`endif

  logic w_tick;
  logic w_enable;

  // The bit timer runs for the whole frame and restarts from 0 at every start bit.
  assign w_enable = (r_state != ST_IDLE);

  uart_baud_tick #(
    .CLK_PER_BIT(CLK_PER_BIT)
  ) u_baud (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .enable (w_enable),
    .tick   (w_tick)
  );

  // Frame FSM; tx_o, ready_o and busy_o are all registered alongside the state.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_bit_idx <= 3'd0;
      r_tx      <= 1'b1;
      r_ready   <= 1'b1;
      r_busy    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (valid_i && r_ready) begin
            r_shift  <= data_i;
            r_tx     <= 1'b0;
            r_ready  <= 1'b0;
            r_busy   <= 1'b1;
            r_state  <= ST_START;
`ifdef UART_TX_PARITY_EN
            r_parity <= even_parity(data_i);
`endif
          end
        end
        ST_START: begin
          if (w_tick) begin
            r_tx      <= r_shift[0];
            r_shift   <= r_shift >> 1;
            r_bit_idx <= 3'd0;
            r_state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_tick) begin
            if (r_bit_idx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
              r_tx    <= r_parity;
              r_state <= ST_PARITY;
`else
              r_tx    <= 1'b1;
              r_state <= ST_STOP;
`endif
            end else begin
              r_tx      <= r_shift[0];
              r_shift   <= r_shift >> 1;
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (w_tick) begin
            r_tx    <= 1'b1;
            r_state <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          // ready_o rises in the cycle right after the last stop-bit cycle.
          if (w_tick) begin
            r_tx    <= 1'b1;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          // Unreachable encodings recover to a clean idle line.
          r_tx    <= 1'b1;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx_o    = r_tx;
  assign ready_o = r_ready;
  assign busy_o  = r_busy;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx -- scoreboard bench for uart_tx. Instance A (CLK_PER_BIT=4) takes
// directed frames; instance B (CLK_PER_BIT=16) is looped back into a bench
// receiver for all 256 byte values. Build with UART_TX_PARITY_EN to cover 8E1.
`timescale 1ns/1ps
module tb_uart_tx;

  localparam int P  = 4;
  localparam int PL = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       valid_a, ready_a, tx_a, busy_a;
  logic [7:0] data_a;
  logic       valid_b, ready_b, tx_b, busy_b;
  logic [7:0] data_b;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit mon_en = 1'b1;

  logic [7:0]  exp_q[$];
  logic [7:0]  exp_lb[$];
  int          starts[$];
  logic [10:0] last_bits;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx #(.CLK_PER_BIT(P)) u_dut_a (
    .clk_i(clk), .reset_i(reset), .valid_i(valid_a), .ready_o(ready_a),
    .data_i(data_a), .tx_o(tx_a), .busy_o(busy_a)
  );

  uart_tx #(.CLK_PER_BIT(PL)) u_dut_b (
    .clk_i(clk), .reset_i(reset), .valid_i(valid_b), .ready_o(ready_b),
    .data_i(data_b), .tx_o(tx_b), .busy_o(busy_b)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Present a byte on A, wait (bounded) for ready, push the expectation at acceptance.
  task automatic send_a(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    data_a  = b;
    valid_a = 1'b1;
    while (!ready_a && n < 400) begin @(negedge clk); n++; end
    chk("accept_a_timeout", n < 400, 1);
    exp_q.push_back(b);
    @(negedge clk);
    valid_a = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    data_b  = b;
    valid_b = 1'b1;
    while (!ready_b && n < 400) begin @(negedge clk); n++; end
    chk("accept_b_timeout", n < 400, 1);
    exp_lb.push_back(b);
    @(negedge clk);
    valid_b = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || exp_lb.size() != 0) && n < 60000) begin
      @(negedge clk); n++;
    end
    chk("drain_timeout", n < 60000, 1);
    repeat (3) @(negedge clk);
  endtask

  // Monitor A: captures every frame cycle by cycle, checks timing and content.
  initial begin
    logic [7:0] e;
    bit         stable;
    forever begin
      @(negedge clk);
      if (mon_en && tx_a === 1'b0) begin
        starts.push_back(cyc);
        chk("busy_at_start", {busy_a, ready_a}, 2'b10);
        stable    = 1'b1;
        last_bits = '0;
        for (int i = 0; i < NB * P; i++) begin
          if (i > 0) @(negedge clk);
          if (i % P == 0) last_bits[i / P] = tx_a;
          else if (tx_a !== last_bits[i / P]) stable = 1'b0;
          if (i == NB * P - 1) chk("ready_low_last_stop", ready_a, 0);
        end
        chk("bit_stable", stable, 1);
        @(negedge clk);
        chk("ready_after_frame", ready_a, 1);
        chk("frame_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("frame_data", last_bits[8:1], e);
          chk("stop_bit", last_bits[NB-1], 1);
`ifdef UART_TX_PARITY_EN
          chk("parity_bit", last_bits[9], ^e);
`endif
        end
      end
    end
  end

  // Monitor B: loopback receiver sampling mid-bit at CLK_PER_BIT=16.
  initial begin
    logic [7:0] rx;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (tx_b === 1'b0) begin
        repeat (PL / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (PL) @(negedge clk);
          rx[i] = tx_b;
        end
        repeat (PL * (NB - 9)) @(negedge clk);
        chk("loopback_expected", exp_lb.size() != 0, 1);
        if (exp_lb.size() != 0) begin
          e = exp_lb.pop_front();
          chk("loopback_byte", {tx_b, rx}, {1'b1, e});
        end
      end
    end
  end

  initial begin
    bit all_idle;
    reset   = 1'b1;
    valid_a = 1'b0; data_a = 8'h00;
    valid_b = 1'b0; data_b = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_state", {tx_a, ready_a, busy_a}, 3'b110);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Single 0xA5 frame: 0,1,0,1,0,0,1,0,1,1 with 4 cycles per bit.
    send_a(8'hA5);
    wait_drain();
    chk("a5_pattern", last_bits[8:0], 9'b1_0100_1010);

    // Held valid: 0x00 then 0xFF; data changes during frame 1 are ignored.
    @(negedge clk);
    data_a  = 8'h00;
    valid_a = 1'b1;
    @(negedge clk);
    exp_q.push_back(8'h00);
    data_a = 8'hFF;
    exp_q.push_back(8'hFF);
    begin
      int n = 0;
      while (!ready_a && n < 400) begin @(negedge clk); n++; end
      chk("b2b_ready_timeout", n < 400, 1);
    end
    @(negedge clk);
    valid_a = 1'b0;
    wait_drain();
    chk("b2b_gap", starts[$] - starts[$-1], NB * P + 1);

    // valid during busy is ignored; accepted only when ready rises.
    send_a(8'h11);
    repeat (8) @(negedge clk);
    send_a(8'h22);
    wait_drain();
    chk("busy_accept_gap", starts[$] - starts[$-1], NB * P + 1);

    send_a(8'h80);
    send_a(8'h01);
    wait_drain();

    // Reset pulsed in frame cycle 15 of 0x3C aborts the frame for good.
    mon_en = 1'b0;
    @(negedge clk);
    data_a  = 8'h3C;
    valid_a = 1'b1;
    @(negedge clk);
    valid_a = 1'b0;
    repeat (14) @(negedge clk);
    chk("pre_reset_frame", {tx_a, busy_a}, 2'b11);
    reset   = 1'b1;
    valid_a = 1'b1;
    data_a  = 8'h55;
    @(negedge clk);
    chk("abort_state", {tx_a, ready_a, busy_a}, 3'b110);
    reset   = 1'b0;
    valid_a = 1'b0;
    all_idle = 1'b1;
    for (int i = 0; i < NB * P + 4; i++) begin
      @(negedge clk);
      if (tx_a !== 1'b1 || busy_a !== 1'b0) all_idle = 1'b0;
    end
    chk("no_resume", all_idle, 1);
    mon_en = 1'b1;

`ifdef UART_TX_PARITY_EN
    send_a(8'h07);
    wait_drain();
    chk("parity_07", last_bits[9], 1);
    chk("frame_len_07", starts[$] - starts[$-1] > 0, 1);
    send_a(8'h03);
    wait_drain();
    chk("parity_03", last_bits[9], 0);
`endif

    // Loopback of every byte value at CLK_PER_BIT=16.
    for (int v = 0; v < 256; v++) send_b(8'(v));
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
